// File: rtl/ov7670_init_seq.sv
// ov7670_init_seq
// Power-up configuration sequencer for the OV7670 camera. Walks a fixed
// {reg, val} ROM. For each entry it issues one 3-byte SCCB write
// {DEV_ADDR, reg, val} to the sccb_if master. The sequencer handles the
// settle time after the soft reset and reports completion or a stalled bus.
//
// Ports
//   sysclk          in   1   system clock (single clock domain)
//   n_rst           in   1   asynchronous active-low reset
//   start           in   1   one-cycle pulse; re-runs the sequence, honoured only when done
//   sccb_busy       in   1   busy flag from sccb_if
//   sccb_req        out  1   one-cycle write request to sccb_if
//   sccb_send_data  out  24  {DEV_ADDR, reg, val}, held from FETCH to the next FETCH
//   done            out  1   sequence finished (level)
//   error           out  1   an ack timeout occurred (level, meaningful while done=1)
//   index           out  6   current ROM index (debug)
module ov7670_init_seq #(
  parameter int unsigned STARTUP_DELAY_CYCLES = 125_000,
  parameter int unsigned RESET_DELAY_CYCLES   = 1_250_000,
  parameter int unsigned ACK_TIMEOUT_CYCLES   = 1024,
  parameter logic [7:0]  DEV_ADDR             = 8'h42
) (
  input  logic        sysclk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        sccb_busy,
  output logic        sccb_req,
  output logic [23:0] sccb_send_data,
  output logic        done,
  output logic        error,
  output logic [5:0]  index
);

  typedef enum logic [2:0] {
    ST_STARTUP   = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_DELAY     = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  // One counter serves both the startup wait and the delay-marker wait,
  // so it is sized for the longer of the two.
  localparam int unsigned MAX_DELAY = (STARTUP_DELAY_CYCLES > RESET_DELAY_CYCLES) ?
                                      STARTUP_DELAY_CYCLES : RESET_DELAY_CYCLES;
  localparam int CNT_W = $clog2(MAX_DELAY) + 1;
  localparam int TO_W  = $clog2(ACK_TIMEOUT_CYCLES) + 1;

  // Counters start at 0 and the wait ends on N-1, so N=1 is a one-cycle wait.
  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_DELAY_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(RESET_DELAY_CYCLES - 32'd1);
  localparam logic [TO_W-1:0]  ACK_LAST     = TO_W'(ACK_TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_ONE       = TO_W'(1);

  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;
  localparam logic [15:0] ENTRY_END   = 16'hFFFF;

  // Register table: the first entry is COM7 soft reset, which the camera
  // needs time to recover from, hence the delay marker right after it.
  function automatic logic [15:0] rom_entry(input logic [5:0] idx);
    logic [15:0] w;
    case (idx)
      6'd0:    w = 16'h1280;
      6'd1:    w = ENTRY_DELAY;
      6'd2:    w = 16'h1204;
      6'd3:    w = 16'h40D0;
      6'd4:    w = 16'h8C00;
      6'd5:    w = 16'h3A04;
      6'd6:    w = 16'h1100;
      6'd7:    w = 16'h6B0A;
      6'd8:    w = 16'h0C00;
      6'd9:    w = 16'h3E00;
      6'd10:   w = 16'h1713;
      6'd11:   w = 16'h1801;
      6'd12:   w = 16'h3202;
      6'd13:   w = 16'h1903;
      6'd14:   w = 16'h1A7B;
      6'd15:   w = 16'h030A;
      default: w = ENTRY_END;
    endcase
    return w;
  endfunction

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              req_q;
  logic [23:0]       data_q;
  logic              done_q;
  logic              error_q;
  logic [5:0]        index_q;
  logic [15:0]       rom_word_s;

  assign rom_word_s = rom_entry(index_q);

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge sysclk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_STARTUP;
      cnt_q    <= {CNT_W{1'b0}};
      to_cnt_q <= {TO_W{1'b0}};
      req_q    <= 1'b0;
      data_q   <= 24'h000000;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      index_q  <= 6'd0;
    end else begin
      // The request is a single-cycle pulse; only FETCH raises it.
      req_q <= 1'b0;
      case (state_q)
        ST_STARTUP: begin
          if (cnt_q == STARTUP_LAST) begin
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= ST_FETCH;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_FETCH: begin
          if (rom_word_s == ENTRY_END) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (rom_word_s == ENTRY_DELAY) begin
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= ST_DELAY;
          end else begin
            data_q  <= {DEV_ADDR, rom_word_s};
            req_q   <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          to_cnt_q <= {TO_W{1'b0}};
          state_q  <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // Busy has priority, so an ack that arrives on the expiry cycle still counts.
          if (sccb_busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (to_cnt_q == ACK_LAST) begin
            done_q  <= 1'b1;
            error_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_ONE;
          end
        end
        ST_WAIT_DONE: begin
          if (!sccb_busy) begin
            index_q <= index_q + 6'd1;
            state_q <= ST_FETCH;
          end
        end
        ST_DELAY: begin
          if (cnt_q == DELAY_LAST) begin
            cnt_q   <= {CNT_W{1'b0}};
            index_q <= index_q + 6'd1;
            state_q <= ST_FETCH;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_DONE: begin
          if (start) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            index_q <= 6'd0;
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= ST_STARTUP;
          end
        end
        default: begin
          cnt_q   <= {CNT_W{1'b0}};
          state_q <= ST_STARTUP;
        end
      endcase
    end
  end

  assign sccb_req       = req_q;
  assign sccb_send_data = data_q;
  assign done           = done_q;
  assign error          = error_q;
  assign index          = index_q;

endmodule

// File: tb/tb_ov7670_init_seq.sv
// Self-checking bench for ov7670_init_seq. The bench runs the design with
// small delays so that whole sequences stay short. A behavioural sccb_if model
// answers each request, and a monitor logs every write.
module tb_ov7670_init_seq;

  localparam int STARTUP   = 4;
  localparam int RDELAY    = 10;
  localparam int ACKTO     = 8;
  localparam int BUSY_HOLD = 5;
  localparam int NWR       = 15;
  localparam int LOGN      = 256;

  logic        sysclk;
  logic        n_rst;
  logic        start;
  logic        sccb_busy;
  logic        sccb_req;
  logic [23:0] sccb_send_data;
  logic        done;
  logic        error;
  logic [5:0]  index;

  ov7670_init_seq #(
    .STARTUP_DELAY_CYCLES(STARTUP),
    .RESET_DELAY_CYCLES  (RDELAY),
    .ACK_TIMEOUT_CYCLES  (ACKTO),
    .DEV_ADDR            (8'h42)
  ) dut (
    .sysclk        (sysclk),
    .n_rst         (n_rst),
    .start         (start),
    .sccb_busy     (sccb_busy),
    .sccb_req      (sccb_req),
    .sccb_send_data(sccb_send_data),
    .done          (done),
    .error         (error),
    .index         (index)
  );

  // Each record pairs a ROM index with the 24-bit frame that index must produce.
  typedef struct {
    logic [5:0]  idx;
    logic [23:0] data;
  } wr_vec_t;
  wr_vec_t vecs [NWR];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Controls for the busy model; only the main process writes these.
  int busy_rise  = 2;
  bit busy_stuck = 1'b0;

  // Monitor results; only the monitor process writes these.
  int          req_cnt = 0;
  logic [23:0] data_log [LOGN];
  logic [5:0]  idx_log  [LOGN];
  int          req_cyc  [LOGN];
  int          stab_err = 0;
  int          req_busy_err = 0;

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  always @(posedge sysclk) cyc <= cyc + 1;

  // sccb_if model. Busy rises busy_rise cycles after the request cycle and stays high for BUSY_HOLD cycles.
  initial begin : busy_model
    bit b_active;
    int b_t;
    b_active  = 1'b0;
    b_t       = 0;
    sccb_busy = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      if (!n_rst) begin
        sccb_busy = 1'b0;
        b_active  = 1'b0;
      end else if (b_active) begin
        b_t = b_t + 1;
        if (b_t == busy_rise) sccb_busy = 1'b1;
        if (b_t == busy_rise + BUSY_HOLD) begin
          sccb_busy = 1'b0;
          b_active  = 1'b0;
        end
      end else if (sccb_req && !busy_stuck) begin
        b_active = 1'b1;
        b_t      = 0;
      end
    end
  end

  // The monitor logs each request. It also checks that the data is stable until busy falls.
  initial begin : monitor
    logic [23:0] held;
    bit in_xfer;
    bit seen_busy;
    held      = 24'h000000;
    in_xfer   = 1'b0;
    seen_busy = 1'b0;
    forever begin
      @(negedge sysclk);
      if (!n_rst || done) begin
        in_xfer = 1'b0;
      end else if (sccb_req) begin
        if (sccb_busy) req_busy_err = req_busy_err + 1;
        if (req_cnt < LOGN) begin
          data_log[req_cnt] = sccb_send_data;
          idx_log[req_cnt]  = index;
          req_cyc[req_cnt]  = cyc;
        end
        req_cnt   = req_cnt + 1;
        held      = sccb_send_data;
        in_xfer   = 1'b1;
        seen_busy = 1'b0;
      end else if (in_xfer) begin
        if (sccb_send_data !== held) stab_err = stab_err + 1;
        if (sccb_busy) seen_busy = 1'b1;
        else if (seen_busy) in_xfer = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit hit, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge sysclk);
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int when);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge sysclk);
      n = n + 1;
    end
    when = cyc;
    chk("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic check_run(input string tag, input int base);
    chk({tag, "_req_count"}, req_cnt - base, NWR);
    for (int i = 0; i < NWR; i++) begin
      if (base + i < LOGN) begin
        chk($sformatf("%s_wr_data[%0d]", tag, i), {8'd0, data_log[base + i]}, {8'd0, vecs[i].data});
        chk($sformatf("%s_wr_index[%0d]", tag, i), {26'd0, idx_log[base + i]}, {26'd0, vecs[i].idx});
      end
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_end_index"}, {26'd0, index}, 32'd16);
  endtask

  initial begin
    int base;
    int rel_cyc;
    int t_done;
    int n;

    vecs[0]  = '{6'd0,  24'h421280};
    vecs[1]  = '{6'd2,  24'h421204};
    vecs[2]  = '{6'd3,  24'h4240D0};
    vecs[3]  = '{6'd4,  24'h428C00};
    vecs[4]  = '{6'd5,  24'h423A04};
    vecs[5]  = '{6'd6,  24'h421100};
    vecs[6]  = '{6'd7,  24'h426B0A};
    vecs[7]  = '{6'd8,  24'h420C00};
    vecs[8]  = '{6'd9,  24'h423E00};
    vecs[9]  = '{6'd10, 24'h421713};
    vecs[10] = '{6'd11, 24'h421801};
    vecs[11] = '{6'd12, 24'h423202};
    vecs[12] = '{6'd13, 24'h421903};
    vecs[13] = '{6'd14, 24'h421A7B};
    vecs[14] = '{6'd15, 24'h42030A};

    n_rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("rst_req",   {31'd0, sccb_req}, 32'd0);
    chk("rst_data",  {8'd0, sccb_send_data}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_index", {26'd0, index}, 32'd0);

    // Normal run, starting automatically when reset is released.
    base    = req_cnt;
    rel_cyc = cyc;
    n_rst   = 1'b1;
    wait_done(3000, t_done);
    check_run("run1", base);
    if (req_cnt > base + 1) begin
      // Cycle 1 is the first cycle after release; the first request is in cycle STARTUP+2.
      chk("first_req_cycle", req_cyc[base] - rel_cyc + 1, STARTUP + 2);
      chk("gap_over_delay", {31'd0, (req_cyc[base + 1] - req_cyc[base]) >= RDELAY}, 32'd1);
    end

    // Restart from DONE. A second start in mid-sequence must be ignored.
    base = req_cnt;
    pulse_start();
    chk("restart_done_drop", {31'd0, done}, 32'd0);
    chk("restart_index_clr", {26'd0, index}, 32'd0);
    n = 0;
    while (req_cnt < base + 3 && n < 1000) begin
      @(negedge sysclk);
      n = n + 1;
    end
    chk("mid_reached", {31'd0, req_cnt >= base + 3}, 32'd1);
    pulse_start();
    chk("mid_start_no_done", {31'd0, done}, 32'd0);
    wait_done(3000, t_done);
    check_run("run2", base);

    // Ack timeout with busy stuck low.
    busy_stuck = 1'b1;
    base = req_cnt;
    pulse_start();
    wait_done(500, t_done);
    chk("to_error", {31'd0, error}, 32'd1);
    chk("to_index", {26'd0, index}, 32'd0);
    chk("to_req_count", req_cnt - base, 32'd1);
    if (req_cnt > base)
      chk("to_latency", t_done - (req_cyc[base] + 1), ACKTO);
    busy_stuck = 1'b0;

    // Busy rises exactly on the expiry cycle of every write.
    busy_rise = ACKTO;
    base = req_cnt;
    pulse_start();
    wait_done(5000, t_done);
    check_run("coinc", base);
    busy_rise = 2;

    // Reset asserted while the index-5 write is busy.
    pulse_start();
    n = 0;
    while (!(index == 6'd5 && sccb_busy === 1'b1) && n < 1000) begin
      @(negedge sysclk);
      n = n + 1;
    end
    chk("rst_mid_reached", {31'd0, (index == 6'd5) && (sccb_busy === 1'b1)}, 32'd1);
    chk("rst_mid_data_before", {8'd0, sccb_send_data}, 32'h00423A04);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_req",   {31'd0, sccb_req}, 32'd0);
    chk("arst_data",  {8'd0, sccb_send_data}, 32'd0);
    chk("arst_done",  {31'd0, done}, 32'd0);
    chk("arst_error", {31'd0, error}, 32'd0);
    chk("arst_index", {26'd0, index}, 32'd0);
    repeat (2) @(negedge sysclk);
    base  = req_cnt;
    n_rst = 1'b1;
    wait_done(3000, t_done);
    check_run("after_rst", base);

    chk("data_stable", stab_err, 32'd0);
    chk("no_req_while_busy", req_busy_err, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ov7670_init_seq.md
# ov7670_init_seq

Power-up configuration sequencer for the OV7670 camera. Walks a fixed register ROM and issues one 3-byte SCCB write per entry to the `sccb_if` master: device address, register, value. Handles the soft-reset settle delay and flags completion or a stalled bus. Sits directly upstream of `sccb_if` in the camera front end and drives its `req`/`send_data` and watches its `busy`.

## Interface

Parameters:
- `STARTUP_DELAY_CYCLES`, 125_000 — wait after reset/start before the first write (1 ms at 125 MHz).
- `RESET_DELAY_CYCLES`, 1_250_000 — wait executed at a delay-marker entry (10 ms).
- `ACK_TIMEOUT_CYCLES`, 1024 — maximum cycles from `sccb_req` to `sccb_busy` rising.
- `DEV_ADDR`, 8'h42 — SCCB write address, placed in `sccb_send_data[23:16]`.

Ports:
- `sysclk` — in, 1 — system clock; everything is in this single domain.
- `n_rst` — in, 1 — asynchronous, active-low reset.
- `start` — in, 1 — one-cycle pulse that re-runs the full sequence.
- `sccb_busy` — in, 1 — busy flag from `sccb_if`.
- `sccb_req` — out, 1 — one-cycle write request to `sccb_if`.
- `sccb_send_data` — out, 24 — `{DEV_ADDR, reg, val}`.
- `done` — out, 1 — sequence finished. Level signal.
- `error` — out, 1 — an ack timeout occurred. Level signal; valid while `done`=1.
- `index` — out, 6 — current ROM index, for debug.

## Operation

- ROM has 16-bit entries `{reg, val}`. Two special entries:
  - `16'hFFF0` = delay marker: wait `RESET_DELAY_CYCLES`, issue no write.
  - `16'hFFFF` = terminator.
- ROM contents, in order: 1280, FFF0, 1204, 40D0, 8C00, 3A04, 1100, 6B0A, 0C00, 3E00, 1713, 1801, 3202, 1903, 1A7B, 030A, FFFF.
- States:
  - RESET → STARTUP (count `STARTUP_DELAY_CYCLES`) → FETCH.
  - FETCH:
    - Terminator → DONE.
    - Delay marker → DELAY.
    - Otherwise → ISSUE.
  - ISSUE: drive `sccb_req`=1 for one cycle → WAIT_ACK.
  - WAIT_ACK:
    - `sccb_busy`=1 → WAIT_DONE.
    - Timeout counter reaches `ACK_TIMEOUT_CYCLES` → set `error`, → DONE.
  - WAIT_DONE: `sccb_busy`=0 → increment `index` → FETCH.
  - DELAY: count `RESET_DELAY_CYCLES` → increment `index` → FETCH.
  - DONE: `done`=1; hold until `start`.
- `start`:
  - Honoured only in DONE: clears `done`, `error`, `index`; → STARTUP.
  - Ignored in every other state.
- Leaving reset starts the sequence automatically. No `start` is needed.
- `sccb_send_data` is registered. It is loaded in FETCH and held constant until the next FETCH.
- Delay counters are sized to `$clog2(max(STARTUP_DELAY_CYCLES, RESET_DELAY_CYCLES))+1` bits. They count from 0 and exit when count == N-1. N=1 therefore gives a one-cycle wait.
- `index` never wraps. The terminator is reached before index 63.

## Timing

- Reset values: `sccb_req`=0, `sccb_send_data`=0, `done`=0, `error`=0, `index`=0. State = STARTUP with counter 0.
- Reset asserted mid-transfer: all outputs return to their reset values immediately (asynchronous). The sequence restarts from index 0 after release. `sccb_if` is reset by the same `n_rst`.
- First `sccb_req`: cycle `STARTUP_DELAY_CYCLES`+2 after reset release (STARTUP, then FETCH, then ISSUE).
- `sccb_req` is never asserted while `sccb_busy`=1. Only one request is outstanding at a time.
- Busy rising in the same cycle the timeout counter expires: treated as ack; no error.
- Overhead per write: 3 cycles beyond the `sccb_busy` high time (FETCH, ISSUE, and at least one WAIT_ACK cycle).
- `done` rises one cycle after FETCH sees the terminator. On the timeout path, `done` and `error` rise in the same cycle.

## Test plan

1. **Normal run.** Params 4/10/8; busy model goes high 2 cycles after req and stays high 5 cycles.
   - 15 `sccb_req` pulses. First `sccb_send_data`=24'h421280, last =24'h42030A.
   - Gap between first and second write ≥ 10 cycles (delay marker).
   - `done`=1 with `error`=0.
2. **Ack timeout.** `sccb_busy` stuck 0.
   - Exactly 1 req.
   - `done`=`error`=1 exactly 8 cycles after WAIT_ACK entry; `index`=0.
3. **Restart.**
   - After a completed run, `start` pulse → `done` drops next cycle; full 15-write sequence repeats.
   - `start` pulsed mid-sequence → ignored; write count unchanged.
4. **Reset mid-transfer.**
   - Drop `n_rst` while `sccb_busy`=1 at index 5 → all outputs 0 asynchronously, without waiting for a clock edge.
   - After release, first write is again 24'h421280.
5. **Coincident ack.** Busy rises on the exact timeout cycle → no error; sequence continues to `done`.
6. **Data stability.** Check that `sccb_send_data` does not change between its req and busy falling, for every write.
